alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Initiator for the team's registered arithmetic unit.
- Accepts operation requests over a valid/ready handshake and registers the operands.
- Drives the unit's A/B/ALU_FUN/enable inputs for exactly one cycle, then waits for the registered result and flag.
- Returns result, carry and status over a valid/ready response channel. Sits between the instruction decoder and the arithmetic unit.

Parameters:
- DATA_WIDTH, 16, operand/result width; matches the arithmetic unit's data widths.
- TIMEOUT_CYCLES, 4, WAIT cycles allowed for Arith_Flag before declaring a timeout; legal range 1..255.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- Clk  in  1  clock; all flops rising-edge.
- RST  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  DATA_WIDTH  operand A.
- req_b  in  DATA_WIDTH  operand B.
- req_fun  in  2  00 add, 01 sub, 10 mul, 11 div.
- A  out  DATA_WIDTH  to arithmetic unit.
- B  out  DATA_WIDTH  to arithmetic unit.
- ALU_FUN  out  2  to arithmetic unit.
- Arithmaitc_Enable  out  1  one-cycle issue strobe to arithmetic unit.
- Arith_out  in  DATA_WIDTH  registered result from arithmetic unit.
- Arith_Flag  in  1  registered result-valid from arithmetic unit.
- Carry_out  in  1  registered carry from arithmetic unit.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_WIDTH  captured result.
- rsp_carry  out  1  captured carry.
- rsp_err  out  2  status: 00 ok, 01 timeout, 10 divide-by-zero (optional feature only).
- op_count  out  CNT_WIDTH  number of completed response handshakes; wraps to 0.

Behaviour:
Reset:
- RST low forces state IDLE, clears operand regs, response regs, timer and op_count.
- All outputs are 0 during reset, except req_ready, which is 0 while RST is low and 1 in the first cycle after release.
- Reset mid-operation abandons the operation; no response is produced for it.

FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture req_a/req_b/req_fun into operand regs and go to ISSUE.
- ISSUE: Arithmaitc_Enable=1 for this single cycle only. Clear the timer. Go to WAIT.
- WAIT: Arithmaitc_Enable=0. If Arith_Flag=1, capture Arith_out→rsp_data, Carry_out→rsp_carry, set rsp_err=00, go to RESP. Otherwise increment the timer. When timer reaches TIMEOUT_CYCLES-1 with no flag, set rsp_data=0, rsp_carry=0, rsp_err=01, go to RESP.
- RESP: rsp_valid=1, with rsp_data/rsp_carry/rsp_err held stable until rsp_valid&&rsp_ready. On that handshake: op_count+1 (wraps), go to IDLE, rsp_valid drops next cycle.

ALU drive:
- A/B/ALU_FUN are driven continuously from the operand regs, so they are stable from ISSUE through WAIT.
- Arithmaitc_Enable is 0 in all states except ISSUE.

Timing and boundaries:
- Nominal latency: request accepted at edge T → ISSUE in cycle T+1 → flag seen in WAIT at T+2 → rsp_valid=1 in cycle T+3.
- One operation in flight at a time; req_ready=0 in ISSUE/WAIT/RESP.
- Minimum request spacing with rsp_ready tied high is 4 cycles.
- req_valid while not ready is ignored; requesters must hold the request.
- rsp_ready asserted before rsp_valid has no effect.
- Carry_out is passed through unmodified.
- Arithmetic results are those of the unit, truncated to DATA_WIDTH; the sequencer performs no arithmetic beyond the timer and counter.

Optional Feature:
Macro: ALU_SEQ_DIV_ZERO_CHECK_EN.
- Defined: in IDLE, an accepted request with req_fun=11 and req_b=0 skips ISSUE/WAIT and goes straight to RESP with rsp_data=0, rsp_carry=0, rsp_err=10. The arithmetic unit is never enabled. The response appears one cycle after acceptance, and op_count increments on its handshake as usual.
- Undefined: such requests are issued normally and the unit's output is returned with rsp_err=00; rsp_err=10 never occurs.

Test Plan:
- Add: reset, then req a=0x0003 b=0x0004 fun=00 → Arithmaitc_Enable high exactly one cycle; rsp_valid 3 cycles after acceptance; rsp_data=0x0007, rsp_err=00; op_count=1.
- Backpressure: req a=0x0010 b=0x0003 fun=01, rsp_ready low 5 cycles → rsp_valid and rsp_data=0x000D held stable; req_ready=0 throughout; op_count increments only on the handshake.
- Timeout: flag-response model never asserts Arith_Flag, TIMEOUT_CYCLES=4 → 4 WAIT cycles, then rsp_err=01, rsp_data=0.
- Divide by zero: a=0x0064 b=0 fun=11. With the macro: rsp_err=10 one cycle after acceptance and Arithmaitc_Enable never asserted. Without the macro: normal issue and rsp_err=00.
- Reset mid-op: pull RST low during WAIT → all outputs 0 immediately; after release req_ready=1, no stale rsp_valid, op_count=0.
- Wrap and back-to-back: 65536 consecutive mul ops with rsp_ready high → op_count wraps to 0; every rsp_data equals (a*b) mod 2^16.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: request/response front end for the registered arithmetic
// unit. Captures one operation, strobes the unit for a single cycle, waits a
// bounded number of cycles for its result flag and returns result/carry/status.
// Optional build macro ALU_SEQ_DIV_ZERO_CHECK_EN: divide requests with a zero
// divisor are answered directly with status 10 and never reach the unit.
module alu_op_sequencer #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                  Clk,
   input  logic                  RST,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   input  logic [1:0]            req_fun,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] B,
   output logic [1:0]            ALU_FUN,
   output logic                  Arithmaitc_Enable,
   input  logic [DATA_WIDTH-1:0] Arith_out,
   input  logic                  Arith_Flag,
   input  logic                  Carry_out,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_carry,
   output logic [1:0]            rsp_err,
   output logic [CNT_WIDTH-1:0]  op_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_DIV0    = 2'b10;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [1:0]            fun_q;
   logic [7:0]            timer_q, timer_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  carry_q, carry_d;
   logic [1:0]            err_q, err_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  accept;
   logic                  rsp_done;
   logic                  div_zero;

   // req_ready is gated by RST so it reads 0 throughout reset even though
   // the state register already sits in IDLE.
   assign req_ready = (state_q == S_IDLE) && RST;
   assign accept    = req_valid && req_ready;
   assign rsp_done  = (state_q == S_RESP) && rsp_ready;

`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
   assign div_zero = (req_fun == 2'b11) && (req_b == '0);
`else
   assign div_zero = 1'b0;
`endif

   assign A                 = a_q;
   assign B                 = b_q;
   assign ALU_FUN           = fun_q;
   assign Arithmaitc_Enable = (state_q == S_ISSUE);
   assign rsp_valid         = (state_q == S_RESP);
   assign rsp_data          = data_q;
   assign rsp_carry         = carry_q;
   assign rsp_err           = err_q;
   assign op_count          = cnt_q;

   // State, operand, response, timer and counter registers.
   always_ff @(posedge Clk or negedge RST) begin
      if (!RST) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         fun_q   <= '0;
         timer_q <= '0;
         data_q  <= '0;
         carry_q <= 1'b0;
         err_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         data_q  <= data_d;
         carry_q <= carry_d;
         err_q   <= err_d;
         if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            fun_q <= req_fun;
         end
         if (rsp_done) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Next-state, timer and response capture.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      data_d  = data_q;
      carry_d = carry_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (div_zero) begin
                  data_d  = '0;
                  carry_d = 1'b0;
                  err_d   = ERR_DIV0;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            timer_d = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (Arith_Flag) begin
               data_d  = Arith_out;
               carry_d = Carry_out;
               err_d   = ERR_OK;
               state_d = S_RESP;
            end else if (timer_q == TIMER_LAST) begin
               data_d  = '0;
               carry_d = 1'b0;
               err_d   = ERR_TIMEOUT;
               state_d = S_RESP;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
